shutdown_fault_monitor: RTL

Downstream consumer of the 8-channel sticky shutdown-sense vector produced by the multiplexed shutdown-sense sampler. Qualifies the vector against an arm control and a channel mask, trips a latched fault on the first unmasked flag, and records which channel tripped first, the full set of flags, a trip timestamp and a saturating trip count. On software acknowledge it issues a one-cycle clear pulse to the upstream sampler's reset and waits out a holdoff window before re-arming.

---
 rtl/shutdown_fault_monitor_if.sv | 29 ++
 rtl/shutdown_fault_monitor.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/shutdown_fault_monitor_if.sv
// Bus for shutdown_fault_monitor. It carries the arm/mask/sense/ack controls into the
// monitor and the latched fault capture outputs back out.
interface shutdown_fault_monitor_if #(
    parameter int TS_WIDTH = 32
);
    logic                arm;
    logic [7:0]          channel_mask;
    logic [7:0]          shutdown_sense;
    logic                fault_ack;
    logic                shutdown_sense_clr;
    logic                fault;
    logic [2:0]          first_fault_ch;
    logic [7:0]          fault_flags;
    logic [TS_WIDTH-1:0] fault_time;
    logic [7:0]          fault_count;
    logic [1:0]          state;

    modport master (
        output arm, channel_mask, shutdown_sense, fault_ack,
        input  shutdown_sense_clr, fault, first_fault_ch, fault_flags,
               fault_time, fault_count, state
    );

    modport slave (
        input  arm, channel_mask, shutdown_sense, fault_ack,
        output shutdown_sense_clr, fault, first_fault_ch, fault_flags,
               fault_time, fault_count, state
    );
endinterface

// File: rtl/shutdown_fault_monitor.sv
// Latched fault monitor for the shutdown-sense vector, with an upstream clear pulse and a re-arm holdoff.
// Define SHUTDOWN_FAULT_TIMESTAMP_EN to build the trip timestamp counter; otherwise fault_time reads 0.
module shutdown_fault_monitor #(
    parameter int TS_WIDTH       = 32,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    shutdown_fault_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_ARMED   = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

    state_t              state_r;
    logic [7:0]          hold_cnt_r;
    logic                clr_r;
    logic                fault_r;
    logic [2:0]          first_ch_r;
    logic [7:0]          flags_r;
    logic [TS_WIDTH-1:0] fault_time_r;
    logic [7:0]          count_r;
    logic [TS_WIDTH-1:0] ts_s;
    logic [7:0]          hit_s;
    logic                trip_s;

    // Bit 0 has the highest priority, so scan downwards and keep the last index that is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Qualify the raw flags against the channel mask
    always_comb begin
        hit_s  = bus.shutdown_sense & ~bus.channel_mask;
        trip_s = (hit_s != 8'h00);
    end

`ifdef SHUTDOWN_FAULT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_r;

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_WIDTH'(1'b1);
        end
    end

    assign ts_s = ts_r;
`else
    assign ts_s = '0;
`endif

    // Monitor FSM and capture registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            hold_cnt_r   <= 8'd0;
            clr_r        <= 1'b0;
            fault_r      <= 1'b0;
            first_ch_r   <= 3'd0;
            flags_r      <= 8'h00;
            fault_time_r <= '0;
            count_r      <= 8'd0;
        end else begin
            clr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.arm) begin
                        state_r    <= ST_HOLDOFF;
                        hold_cnt_r <= 8'd0;
                        clr_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLDOFF: begin
                    // The window always runs to completion; arm is only consulted at its end.
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r <= bus.arm ? ST_ARMED : ST_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                    end
                end
                ST_ARMED: begin
                    if (trip_s) begin
                        state_r      <= ST_FAULT;
                        fault_r      <= 1'b1;
                        first_ch_r   <= lowest_set(hit_s);
                        flags_r      <= hit_s;
                        fault_time_r <= ts_s;
                        count_r      <= (count_r == 8'd255) ? 8'd255 : count_r + 8'd1;
                    end else if (!bus.arm) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_FAULT: begin
                    flags_r <= flags_r | hit_s;
                    if (bus.fault_ack) begin
                        state_r    <= ST_HOLDOFF;
                        fault_r    <= 1'b0;
                        hold_cnt_r <= 8'd0;
                        clr_r      <= 1'b1;
                    end else begin
                        state_r <= ST_FAULT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    fault_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.shutdown_sense_clr = clr_r;
    assign bus.fault              = fault_r;
    assign bus.first_fault_ch     = first_ch_r;
    assign bus.fault_flags        = flags_r;
    assign bus.fault_time         = fault_time_r;
    assign bus.fault_count        = count_r;
    assign bus.state              = state_r;
endmodule
